// File: rtl/wishbone_master_req_pkg.sv
// ============================================================================
// Module : wishbone_master_req_pkg
// Brief  : Response status codes and FSM state encodings for the WB master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wishbone_master_req_pkg;

  localparam logic [1:0] WB_STATUS_OK      = 2'b00;
  localparam logic [1:0] WB_STATUS_BUS_ERR = 2'b01;
  localparam logic [1:0] WB_STATUS_TIMEOUT = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/wishbone_master_req_timeout_counter.sv
// ============================================================================
// Module : wb_timeout_counter
// Brief  : Saturating bus-cycle counter flagging the last permitted BUS cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] c_MAX  = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] c_ONE  = CW'(1);

      logic [CW-1:0] r_count;

      // Saturates instead of wrapping so a stuck enable can never re-arm the abort.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en && (r_count != c_MAX)) begin
          r_count <= r_count + c_ONE;
        end
      end

      assign o_expired = i_en && (r_count == c_LAST);
    end else begin : g_no_timer
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wishbone_master_req.sv
// ============================================================================
// Module : wishbone_master_req
// Brief  : Single-transfer Wishbone classic master with ERR and timeout abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wishbone_master_req
  import wishbone_master_req_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [SEL_W-1:0]  req_sel_i,
  output logic              rsp_valid_o,
  output logic [1:0]        rsp_status_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic [1:0]        r_status;
  logic [DATA_W-1:0] r_rdata;

  logic w_accept;
  logic w_in_bus;
  logic w_expired;

  assign w_accept = (r_state == S_IDLE) && req_valid_i;
  assign w_in_bus = (r_state == S_BUS);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      (w_in_bus),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_status <= WB_STATUS_OK;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we    <= req_we_i;
            r_adr   <= req_addr_i;
            r_dat   <= req_wdata_i;
            r_sel   <= req_sel_i;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          // ERR takes priority over a simultaneous ACK.
          if (wb_err_i) begin
            r_status <= WB_STATUS_BUS_ERR;
            r_state  <= S_RESP;
          end else if (wb_ack_i) begin
            r_status <= WB_STATUS_OK;
            if (!r_we) begin
              r_rdata <= wb_dat_i;
            end
            r_state <= S_RESP;
          end else if (w_expired) begin
            r_status <= WB_STATUS_TIMEOUT;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and bus-control outputs are pure state decodes, so no input reaches them.
  assign req_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state == S_BUS) || (r_state == S_RESP);
  assign rsp_valid_o  = (r_state == S_RESP);
  assign wb_cyc_o     = w_in_bus;
  assign wb_stb_o     = w_in_bus;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;
  assign rsp_status_o = r_status;
  assign rsp_rdata_o  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_master_req.sv
// ============================================================================
// Module : tb_wishbone_master_req
// Brief  : Directed plus randomized bench for wishbone_master_req (timeout 8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wishbone_master_req;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 8;

  // Slave behaviours
  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_sel_i;
  logic          rsp_valid_o;
  logic [1:0]    rsp_status_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          busy_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  wishbone_master_req #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_sel_i    (req_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_status_o (rsp_status_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .busy_o       (busy_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; expectations come from the protocol rules, not the FSM.
  task automatic xfer(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] sel, input int waits, input int kind,
                      input logic [DW-1:0] rd, input bit late_ack);
    int         exp_cyc;
    logic [1:0] exp_st;
    int         cyc_n;
    bit         stable;
    if (kind == K_SILENT || waits >= TO) begin
      exp_cyc = TO;
      exp_st  = 2'b10;
    end else begin
      exp_cyc = waits + 1;
      exp_st  = (kind == K_ACK) ? 2'b00 : 2'b01;
    end
    @(negedge clk);
    chk("ready_idle", {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = adr;
    req_wdata_i = wd;
    req_sel_i   = sel;
    wb_dat_i    = rd;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i  = ~adr;
    req_wdata_i = ~wd;
    chk("busy_in_bus", {63'd0, busy_o}, 64'd1);
    cyc_n  = 0;
    stable = 1'b1;
    while (wb_cyc_o && cyc_n < TO + 4) begin
      cyc_n++;
      if (wb_stb_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== adr ||
          wb_dat_o !== wd || wb_sel_o !== sel || req_ready_o !== 1'b0)
        stable = 1'b0;
      wb_ack_i = (cyc_n - 1 == waits) && (kind == K_ACK || kind == K_BOTH);
      wb_err_i = (cyc_n - 1 == waits) && (kind == K_ERR || kind == K_BOTH);
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("bus_stable", {63'd0, stable}, 64'd1);
    chk("cyc_cycles", 64'(cyc_n), 64'(exp_cyc));
    chk("rsp_valid_hi", {63'd0, rsp_valid_o}, 64'd1);
    chk("rsp_status", {62'd0, rsp_status_o}, {62'd0, exp_st});
    if (!we && exp_st == 2'b00) m_rdata = rd;
    chk("rsp_rdata", rsp_rdata_o, m_rdata);
    wb_ack_i = late_ack;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("rsp_pulse_end", {62'd0, rsp_valid_o, wb_cyc_o}, 64'd0);
    chk("ready_again", {62'd0, req_ready_o, busy_o}, 64'd2);
    if (late_ack) begin
      @(negedge clk);
      chk("late_ack_ignored", {61'd0, rsp_valid_o, wb_cyc_o, req_ready_o}, 64'd1);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_sel_i   = '0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    m_rdata     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_ctl", {60'd0, wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o}, 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read acked in the first BUS cycle
    xfer(1'b0, 32'h0000_0010, 64'd0, 8'hFF, 0, K_ACK, 64'h1122_3344_5566_7788, 1'b0);
    // Write acked after five wait states
    xfer(1'b1, 32'h0000_0004, 64'h0000_0000_0000_00A5, 8'h01, 5, K_ACK, 64'hDEAD_BEEF_0000_0001, 1'b0);
    // ACK and ERR together on a read
    xfer(1'b0, 32'h0000_0020, 64'd0, 8'hF0, 2, K_BOTH, 64'hCAFE_F00D_1234_5678, 1'b0);
    // Silent slave, then a late ACK during the response cycle
    xfer(1'b0, 32'h0000_0030, 64'd0, 8'h0F, 0, K_SILENT, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1);
    // ACK arriving one cycle after the deadline is too late
    xfer(1'b0, 32'h0000_0040, 64'd0, 8'hFF, TO, K_ACK, 64'h5555_AAAA_5555_AAAA, 1'b0);
    // Last permitted cycle still completes OK
    xfer(1'b0, 32'h0000_0050, 64'd0, 8'hFF, TO - 1, K_ACK, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Reset while waiting on the bus
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h0000_0060;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", {63'd0, wb_cyc_o}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {61'd0, wb_cyc_o, wb_stb_o, rsp_valid_o}, 64'd0);
    m_rdata = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_quiet", {62'd0, rsp_valid_o, req_ready_o}, 64'd1);
    xfer(1'b0, 32'h0000_0070, 64'd0, 8'h3C, 1, K_ACK, 64'h7777_6666_5555_4444, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 16; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom),
           int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
